adpd_avmm_regs: RTL and testbench
=================================

// Module: adpd_avmm_regs
// PURPOSE
//  Avalon-MM register slave on the NIOS CPU's 8-bit avmm_m0 master port.
//  Holds ADPD control registers, double-buffered (shadow/active) so a whole
//  group updates atomically. Also provides sticky event flags with interrupt
//  output, a start/busy command handshake and an atomic status snapshot.
// PARAMETERS
//  N_CTRL   16     number of RW control bytes (1..64), at 0x00..N_CTRL-1
//  RD_LAT   2      read latency in cycles from read accept to readdatavalid (1 or 2)
//  CMD_TO   255    max waitrequest stall cycles on a CMD write while busy (1..255)
//  ID_VAL   8'hAD  constant returned at the ID address
// PORTS
//  clk              in   1         system clock
//  reset_n          in   1         async active-low reset
//  avs_address      in   8         byte address
//  avs_read         in   1         read request
//  avs_write        in   1         write request
//  avs_writedata    in   8         write data
//  avs_readdata     out  8         read data, valid when avs_readdatavalid=1
//  avs_readdatavalid out 1         one pulse per accepted read
//  avs_waitrequest  out  1         stall; request accepted when req && !waitrequest
//  ctrl_q           out  8*N_CTRL  active control bytes, byte i = ctrl_q[8i+7:8i]
//  ctrl_upd         out  1         1-cycle pulse, coincident with ctrl_q change
//  evt_i            in   8         event pulses, one per sticky bit
//  irq_o            out  1         |(sticky & mask), registered
//  cmd_start        out  1         1-cycle start pulse
//  cmd_busy         in   1         engine busy
//  stat_i           in   64        live status, 8 bytes
// BEHAVIOUR
//  Reset values: all ctrl shadow/active=0, sticky=0, mask=0, snapshot=0;
//  readdatavalid=0, readdata=0, ctrl_upd=0, irq_o=0, cmd_start=0.
//  waitrequest=1 during reset; it drops on the first clk after reset_n rises.
//  Address map (constants in package):
//   0x00..N_CTRL-1  RW shadow ctrl bytes
//   0x40  UPDATE    W: any value copies all shadow to active
//   0x41  EVT       R sticky; W1C
//   0x42  MASK      RW
//   0x43  CMD       W bit0=1 starts; R bit0=cmd_busy, bit7=timeout flag (sticky bit7)
//   0x44  ID        RO ID_VAL
//   0x50  STAT0     R: returns stat_i[7:0] and latches all 64 bits into the snapshot
//   0x51..0x57      R: snapshot bytes 1..7
//   Unmapped: reads return 0x00 with normal latency; writes are ignored.
//  Reads: accept whenever waitrequest=0. Fully pipelined, so back-to-back reads
//   produce back-to-back valids in order. Data is sampled in the accept cycle.
//   Reads have no side effects, except the STAT0 snapshot.
//  Writes: take effect on the accept edge. A shadow write does not change ctrl_q.
//  UPDATE accept: ctrl_q and ctrl_upd change on the next edge (latency 1).
//  Sticky: bit set on evt_i[i]=1. W1C clears it. A set and a clear of the same
//   bit in the same cycle: set wins.
//  irq_o: registered, 1 cycle after sticky or mask changes.
//  CMD FSM, states IDLE / STALL:
//   - IDLE, CMD write bit0=1, cmd_busy=0: accept, cmd_start pulse next cycle.
//   - IDLE, CMD write bit0=1, cmd_busy=1: go to STALL, waitrequest=1, counter loads 0.
//   - STALL, cmd_busy=0: accept the write, issue cmd_start, return to IDLE.
//   - STALL, counter reaches CMD_TO: accept the write, drop it (no start),
//     set sticky bit7, return to IDLE.
//   - CMD write bit0=0: accepted immediately, no effect.
//   - Reads are stalled while in STALL; in-flight read valids still complete.
//  Reset mid-operation: pipeline and FSM cleared, pending valids discarded.
//  A read and write asserted together is illegal; the write takes priority.
// STRUCTURE
//  Package adpd_regs_pkg: address localparams, ID_VAL default, cmd_state_t enum.
//  Sub-module adpd_rd_pipe: RD_LAT-deep data/valid pipeline.
//  All other logic lives in the top module.
// TESTING
//  - Write 0x00=0x12 and 0x01=0x34: ctrl_q unchanged. Write 0x40: next cycle
//    ctrl_q[15:0]=0x3412 and ctrl_upd is a single pulse.
//  - 4 back-to-back reads of 0x44, RD_LAT=2: 4 consecutive valids, each 0xAD,
//    the first 2 cycles after the first accept.
//  - evt_i=0x05, MASK=0x04: irq_o=1. W1C 0x04 with evt_i[2]=1 in the same
//    cycle: bit stays set. W1C 0x04 alone: irq_o=0 one cycle later.
//  - cmd_busy=1, write 0x43=0x01, busy falls after 10 cycles: waitrequest
//    high 10 cycles, then one cmd_start pulse.
//  - CMD_TO=8, busy held high: write accepted after 8 stall cycles, no
//    cmd_start, EVT reads 0x80.
//  - stat_i=0x1122..88, read 0x50, change stat_i, read 0x51: returns the byte
//    latched at the 0x50 read. Assert reset_n mid-read: no stray valid.

Source files
------------

// File: rtl/adpd_regs_pkg.sv
// Shared constants and types for the ADPD Avalon-MM register slave.
package adpd_regs_pkg;

  localparam logic [7:0] ADDR_UPDATE = 8'h40;
  localparam logic [7:0] ADDR_EVT    = 8'h41;
  localparam logic [7:0] ADDR_MASK   = 8'h42;
  localparam logic [7:0] ADDR_CMD    = 8'h43;
  localparam logic [7:0] ADDR_ID     = 8'h44;
  localparam logic [7:0] ADDR_STAT0  = 8'h50;

  localparam logic [7:0] ID_VAL_DEF  = 8'hAD;

  typedef enum logic {
    CMD_IDLE  = 1'b0,
    CMD_STALL = 1'b1
  } cmd_state_t;

endpackage

// File: rtl/adpd_rd_pipe.sv
// Fixed-latency read-return pipeline: data and valid travel together,
// so back-to-back accepted reads come out back-to-back and in order.
module adpd_rd_pipe #(
  parameter int RD_LAT = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       vld_i,
  input  logic [7:0] data_i,
  output logic       vld_o,
  output logic [7:0] data_o
);

  logic [RD_LAT-1:0]      vld_q;
  logic [RD_LAT-1:0][7:0] data_q;

  // Shift valid/data one stage per cycle; reset discards in-flight reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q[0]  <= vld_i;
      data_q[0] <= vld_i ? data_i : 8'h00;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign vld_o  = vld_q[RD_LAT-1];
  assign data_o = data_q[RD_LAT-1];

endmodule

// File: rtl/adpd_avmm_regs.sv
// ADPD control/status register slave on an 8-bit Avalon-MM port:
// double-buffered control bytes, sticky events with IRQ, a start/busy
// command handshake with bounded stall, and a 64-bit status snapshot.
module adpd_avmm_regs
  import adpd_regs_pkg::*;
#(
  parameter int         N_CTRL = 16,
  parameter int         RD_LAT = 2,
  parameter int         CMD_TO = 255,
  parameter logic [7:0] ID_VAL = ID_VAL_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [7:0]          avs_address,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [7:0]          avs_writedata,
  output logic [7:0]          avs_readdata,
  output logic                avs_readdatavalid,
  output logic                avs_waitrequest,
  output logic [8*N_CTRL-1:0] ctrl_q,
  output logic                ctrl_upd,
  input  logic [7:0]          evt_i,
  output logic                irq_o,
  output logic                cmd_start,
  input  logic                cmd_busy,
  input  logic [63:0]         stat_i
);

  localparam logic [7:0] CNT_LAST = 8'(CMD_TO - 1);

  cmd_state_t          state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                rdy_q;
  logic [8*N_CTRL-1:0] shadow_q, active_q;
  logic                upd_pend_q, upd_q;
  logic [7:0]          sticky_q, sticky_d, mask_q;
  logic                irq_q, start_q;
  logic [63:0]         snap_q;

  logic                cmd_wr, stall, start_now, to_set;
  logic                wr_acc, rd_acc;
  logic [7:0]          w1c, rd_data;

  // A CMD write only needs the FSM when it actually requests a start.
  assign cmd_wr          = avs_write && (avs_address == ADDR_CMD) && avs_writedata[0];
  assign avs_waitrequest = !rdy_q || stall;
  assign wr_acc          = avs_write && !avs_waitrequest;
  // Write wins over a simultaneous read.
  assign rd_acc          = avs_read && !avs_write && !avs_waitrequest;

  // Hold waitrequest high until the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdy_q <= 1'b0;
    else          rdy_q <= 1'b1;
  end

  // CMD FSM next state: stall a start request while the engine is busy,
  // giving up after CMD_TO stall cycles in total.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall     = 1'b0;
    start_now = 1'b0;
    to_set    = 1'b0;
    case (state_q)
      CMD_IDLE: begin
        if (rdy_q && cmd_wr) begin
          if (cmd_busy) begin
            state_d = CMD_STALL;
            cnt_d   = 8'd0;
            stall   = 1'b1;
          end else begin
            start_now = 1'b1;
          end
        end
      end
      CMD_STALL: begin
        if (!cmd_busy) begin
          start_now = 1'b1;
          state_d   = CMD_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          to_set  = 1'b1;
          state_d = CMD_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          stall = 1'b1;
        end
      end
      default: state_d = CMD_IDLE;
    endcase
  end

  // CMD FSM state and stall counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CMD_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Shadow control bytes and the IRQ mask take writes on the accept edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q <= '0;
      mask_q   <= 8'h00;
    end else if (wr_acc) begin
      for (int i = 0; i < N_CTRL; i++)
        if (avs_address == 8'(i)) shadow_q[8*i +: 8] <= avs_writedata;
      if (avs_address == ADDR_MASK) mask_q <= avs_writedata;
    end
  end

  // Copy shadow to active one edge after an UPDATE write, pulsing ctrl_upd
  // in the same cycle the new values appear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      upd_pend_q <= 1'b0;
      upd_q      <= 1'b0;
      active_q   <= '0;
    end else begin
      upd_pend_q <= wr_acc && (avs_address == ADDR_UPDATE);
      upd_q      <= upd_pend_q;
      if (upd_pend_q) active_q <= shadow_q;
    end
  end

  // Sticky flags: a new event outranks a same-cycle W1C; bit7 records a CMD timeout.
  always_comb begin
    w1c      = (wr_acc && (avs_address == ADDR_EVT)) ? avs_writedata : 8'h00;
    sticky_d = (sticky_q & ~w1c) | evt_i | {to_set, 7'b0};
  end

  // Sticky flags, registered IRQ and the one-cycle start pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sticky_q <= 8'h00;
      irq_q    <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
      irq_q    <= |(sticky_q & mask_q);
      start_q  <= start_now;
    end
  end

  // Reading STAT0 freezes all eight status bytes for the following reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              snap_q <= 64'h0;
    else if (rd_acc && (avs_address == ADDR_STAT0)) snap_q <= stat_i;
  end

  // Read data mux, sampled in the accept cycle; unmapped addresses read 0.
  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < N_CTRL; i++)
      if (avs_address == 8'(i)) rd_data = shadow_q[8*i +: 8];
    for (int k = 1; k < 8; k++)
      if (avs_address == (ADDR_STAT0 + 8'(k))) rd_data = snap_q[8*k +: 8];
    case (avs_address)
      ADDR_EVT:   rd_data = sticky_q;
      ADDR_MASK:  rd_data = mask_q;
      ADDR_CMD:   rd_data = {sticky_q[7], 6'b0, cmd_busy};
      ADDR_ID:    rd_data = ID_VAL;
      ADDR_STAT0: rd_data = stat_i[7:0];
      default:    ;
    endcase
  end

  adpd_rd_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .vld_i   (rd_acc),
    .data_i  (rd_data),
    .vld_o   (avs_readdatavalid),
    .data_o  (avs_readdata)
  );

  assign ctrl_q    = active_q;
  assign ctrl_upd  = upd_q;
  assign irq_o     = irq_q;
  assign cmd_start = start_q;

endmodule

// File: tb/tb_adpd_avmm_regs.sv
// Directed bench for adpd_avmm_regs with a read-return scoreboard.
module tb_adpd_avmm_regs;

  localparam int N_CTRL = 16;
  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance (CMD_TO default)
  logic [7:0]          avs_address = 8'h00;
  logic                avs_read = 1'b0;
  logic                avs_write = 1'b0;
  logic [7:0]          avs_writedata = 8'h00;
  logic [7:0]          avs_readdata;
  logic                avs_readdatavalid;
  logic                avs_waitrequest;
  logic [8*N_CTRL-1:0] ctrl_q;
  logic                ctrl_upd;
  logic [7:0]          evt_i = 8'h00;
  logic                irq_o;
  logic                cmd_start;
  logic                cmd_busy = 1'b0;
  logic [63:0]         stat_i = 64'h0;

  // Timeout instance (CMD_TO = 8)
  logic [7:0]          to_addr = 8'h00;
  logic                to_read = 1'b0;
  logic                to_write = 1'b0;
  logic [7:0]          to_wdata = 8'h00;
  logic [7:0]          to_rdata;
  logic                to_rdv;
  logic                to_wait;
  logic [8*N_CTRL-1:0] to_ctrl;
  logic                to_upd;
  logic [7:0]          to_evt = 8'h00;
  logic                to_irq;
  logic                to_start;
  logic                to_busy = 1'b0;
  logic [63:0]         to_stat = 64'h0;

  adpd_avmm_regs #(.N_CTRL(N_CTRL), .RD_LAT(RD_LAT)) u_dut (
    .clk (clk), .reset_n (reset_n),
    .avs_address (avs_address), .avs_read (avs_read), .avs_write (avs_write),
    .avs_writedata (avs_writedata), .avs_readdata (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid), .avs_waitrequest (avs_waitrequest),
    .ctrl_q (ctrl_q), .ctrl_upd (ctrl_upd), .evt_i (evt_i), .irq_o (irq_o),
    .cmd_start (cmd_start), .cmd_busy (cmd_busy), .stat_i (stat_i)
  );

  adpd_avmm_regs #(.N_CTRL(N_CTRL), .RD_LAT(RD_LAT), .CMD_TO(8)) u_to (
    .clk (clk), .reset_n (reset_n),
    .avs_address (to_addr), .avs_read (to_read), .avs_write (to_write),
    .avs_writedata (to_wdata), .avs_readdata (to_rdata),
    .avs_readdatavalid (to_rdv), .avs_waitrequest (to_wait),
    .ctrl_q (to_ctrl), .ctrl_upd (to_upd), .evt_i (to_evt), .irq_o (to_irq),
    .cmd_start (to_start), .cmd_busy (to_busy), .stat_i (to_stat)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_start = 0;
  int n_to_start = 0;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;
  exp_t  sb[$];
  string sb_tag[$];
  exp_t  mon_e;
  string mon_t;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard: every returned read is matched against the oldest expectation.
  always @(negedge clk) begin
    if (cmd_start) n_start++;
    if (to_start)  n_to_start++;
    if (avs_readdatavalid) begin
      n_vec++;
      assert (sb.size() > 0) else begin
        n_err++;
        $error("FAIL stray_valid: observed readdata 0x%0h expected no valid", avs_readdata);
      end
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        mon_t = sb_tag.pop_front();
        chk(mon_t, 64'(avs_readdata), 64'(mon_e.data));
        chk({mon_t, "_lat"}, 64'(cyc - mon_e.cyc), 64'(RD_LAT));
      end
    end
  end

  // All bus tasks start and end 1 ns after a rising edge.
  task automatic bus_write(input logic [7:0] a, input logic [7:0] d, output int stalls);
    bit acc;
    acc = 1'b0;
    stalls = 0;
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    for (int i = 0; i < 400 && !acc; i++) begin
      @(negedge clk);
      acc = !avs_waitrequest;
      if (!acc) stalls++;
      @(posedge clk); #1;
    end
    avs_write = 1'b0;
    chk("wr_accept", 64'(acc), 64'(1));
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    int s;
    bus_write(a, d, s);
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string tag, input bit push = 1'b1);
    bit acc;
    exp_t e;
    acc = 1'b0;
    avs_address = a; avs_read = 1'b1;
    for (int i = 0; i < 400 && !acc; i++) begin
      @(negedge clk);
      acc = !avs_waitrequest;
      if (acc && push) begin
        e.data = exp; e.cyc = cyc;
        sb.push_back(e);
        sb_tag.push_back(tag);
      end
      @(posedge clk); #1;
    end
    avs_read = 1'b0;
    chk({tag, "_accept"}, 64'(acc), 64'(1));
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  st;
    int  s0;
    bit  acc;

    // ---------------- reset values ----------------
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_waitreq", 64'(avs_waitrequest), 64'(1));
    chk("rst_rdv",     64'(avs_readdatavalid), 64'(0));
    chk("rst_rdata",   64'(avs_readdata), 64'(0));
    chk("rst_ctrl",    64'(|ctrl_q), 64'(0));
    chk("rst_upd",     64'(ctrl_upd), 64'(0));
    chk("rst_irq",     64'(irq_o), 64'(0));
    chk("rst_start",   64'(cmd_start), 64'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("wait_after_release", 64'(avs_waitrequest), 64'(1));
    @(posedge clk); #1;
    chk("wait_dropped", 64'(avs_waitrequest), 64'(0));

    // ---------------- shadow / update ----------------
    wr(8'h00, 8'h12);
    wr(8'h01, 8'h34);
    chk("shadow_no_effect", 64'(ctrl_q[15:0]), 64'(0));
    wr(8'h40, 8'h00);
    chk("upd_e1_ctrl",  64'(ctrl_q[15:0]), 64'(0));
    chk("upd_e1_pulse", 64'(ctrl_upd), 64'(0));
    @(posedge clk); #1;
    chk("upd_ctrl",  64'(ctrl_q[15:0]), 64'h3412);
    chk("upd_pulse", 64'(ctrl_upd), 64'(1));
    @(posedge clk); #1;
    chk("upd_pulse_end", 64'(ctrl_upd), 64'(0));
    chk("upd_ctrl_hold", 64'(ctrl_q[15:0]), 64'h3412);
    rd(8'h01, 8'h34, "shadow_rd");

    // ---------------- back-to-back reads ----------------
    rd(8'h44, 8'hAD, "id0");
    rd(8'h44, 8'hAD, "id1");
    rd(8'h44, 8'hAD, "id2");
    rd(8'h44, 8'hAD, "id3");
    rd(8'h60, 8'h00, "unmapped60");
    rd(8'h10, 8'h00, "unmapped10");
    drain();

    // ---------------- sticky events / irq ----------------
    evt_i = 8'h05;
    @(posedge clk); #1;
    evt_i = 8'h00;
    wr(8'h42, 8'h04);
    chk("irq_pre", 64'(irq_o), 64'(0));
    @(posedge clk); #1;
    chk("irq_set", 64'(irq_o), 64'(1));
    evt_i = 8'h04;
    wr(8'h41, 8'h04);
    evt_i = 8'h00;
    rd(8'h41, 8'h05, "evt_set_wins");
    chk("irq_hold", 64'(irq_o), 64'(1));
    wr(8'h41, 8'h04);
    chk("irq_lag", 64'(irq_o), 64'(1));
    @(posedge clk); #1;
    chk("irq_clr", 64'(irq_o), 64'(0));
    rd(8'h41, 8'h01, "evt_after_w1c");
    rd(8'h42, 8'h04, "mask_rd");
    wr(8'h41, 8'h01);
    rd(8'h41, 8'h00, "evt_cleared");
    drain();

    // ---------------- command handshake ----------------
    wr(8'h43, 8'h00);
    @(negedge clk);
    chk("cmd0_nostart", 64'(cmd_start), 64'(0));
    @(posedge clk); #1;
    bus_write(8'h43, 8'h01, st);
    chk("cmd_idle_stalls", 64'(st), 64'(0));
    @(negedge clk);
    chk("cmd_idle_start", 64'(cmd_start), 64'(1));
    @(negedge clk);
    chk("cmd_idle_start_end", 64'(cmd_start), 64'(0));
    @(posedge clk); #1;

    cmd_busy = 1'b1;
    rd(8'h43, 8'h01, "cmd_rd_busy");
    s0 = n_start;
    fork
      bus_write(8'h43, 8'h01, st);
      begin
        repeat (10) @(posedge clk);
        #1 cmd_busy = 1'b0;
      end
    join
    chk("cmd_stall_cycles", 64'(st), 64'(10));
    chk("cmd_no_early_start", 64'(n_start - s0), 64'(0));
    @(negedge clk);
    chk("cmd_busy_start", 64'(cmd_start), 64'(1));
    @(negedge clk);
    chk("cmd_busy_start_end", 64'(cmd_start), 64'(0));
    chk("cmd_one_start", 64'(n_start - s0), 64'(1));
    @(posedge clk); #1;
    drain();

    // ---------------- command timeout (CMD_TO = 8) ----------------
    to_busy = 1'b1;
    to_addr = 8'h43; to_wdata = 8'h01; to_write = 1'b1;
    st = 0; acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      acc = !to_wait;
      if (!acc) st++;
      @(posedge clk); #1;
    end
    to_write = 1'b0;
    chk("to_accept", 64'(acc), 64'(1));
    chk("to_stall_cycles", 64'(st), 64'(8));
    @(negedge clk);
    @(posedge clk); #1;
    chk("to_no_start", 64'(n_to_start), 64'(0));
    to_addr = 8'h41; to_read = 1'b1;
    @(negedge clk);
    chk("to_rd_accept", 64'(to_wait), 64'(0));
    @(posedge clk); #1;
    to_read = 1'b0;
    @(negedge clk);
    chk("to_rdv_early", 64'(to_rdv), 64'(0));
    @(negedge clk);
    chk("to_rdv", 64'(to_rdv), 64'(1));
    chk("to_evt_rd", 64'(to_rdata), 64'h80);
    to_busy = 1'b0;
    @(posedge clk); #1;

    // ---------------- status snapshot ----------------
    stat_i = 64'h1122334455667788;
    rd(8'h50, 8'h88, "stat0");
    stat_i = 64'hFFEEDDCCBBAA9900;
    rd(8'h51, 8'h77, "snap1");
    rd(8'h57, 8'h11, "snap7");
    rd(8'h53, 8'h55, "snap3");
    rd(8'h50, 8'h00, "stat0_live");
    rd(8'h51, 8'h99, "snap1_new");
    drain();

    // ---------------- reset during a read ----------------
    rd(8'h44, 8'hAD, "rst_rd", 1'b0);
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_valid", 64'(avs_readdatavalid), 64'(0));
    end
    chk("rst_mid_waitreq", 64'(avs_waitrequest), 64'(1));
    chk("rst_mid_ctrl", 64'(|ctrl_q), 64'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    rd(8'h44, 8'hAD, "post_rst_id");
    rd(8'h00, 8'h00, "post_rst_shadow");
    rd(8'h42, 8'h00, "post_rst_mask");
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
